switch_port_ingress: RTL
========================

// Module: switch_port_ingress
// PURPOSE
//  Per-port ingress buffer for the 4-port packet switch. Accepts {source,target,data} packets on a
//  valid/ready stream, queues them in a DEPTH-entry FIFO and presents them to the switch fabric
//  on a second valid/ready stream. Adds backpressure or drop-on-full mode, self-address filtering
//  and drop/occupancy statistics. One instance sits between each port interface and the arbiter.
// PARAMETERS
//  PORT_ID      0   id of this port, width ADDR_WIDTH; used by self-address filter
//  DEPTH        4   FIFO entries; power of two, >= 2
//  DROP_ON_FULL 0   0: backpressure via in_ready; 1: in_ready tied 1, packets arriving while full are dropped
//  DROP_SELF    1   1: packets with target == PORT_ID are discarded at ingress
//  CNT_WIDTH    16  width of the saturating drop counter
// PORTS
//  clk          in   1           switch clock, all logic on posedge
//  rst_n        in   1           asynchronous active-low reset
//  in_valid     in   1           upstream packet valid
//  in_ready     out  1           ingress can accept a packet this cycle
//  in_source    in   ADDR_WIDTH  packet source address
//  in_target    in   ADDR_WIDTH  packet target address
//  in_data      in   DATA_WIDTH  packet payload
//  out_valid    out  1           head-of-queue packet valid
//  out_ready    in   1           fabric accepts head packet
//  out_source   out  ADDR_WIDTH  head packet source
//  out_target   out  ADDR_WIDTH  head packet target
//  out_data     out  DATA_WIDTH  head packet payload
//  occupancy    out  $clog2(DEPTH+1)  entries currently stored
//  drop_cnt     out  CNT_WIDTH   packets discarded (full or self-addressed), saturating
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers, occupancy, drop_cnt = 0; out_valid = 0;
//    out_source/out_target/out_data = 0; FIFO contents are not reset.
//  - in_ready = DROP_ON_FULL ? 1 : (occupancy != DEPTH). Derived from registered state only; no
//    combinational path from out_ready to in_ready.
//  - Accept = in_valid & in_ready. Write = accept & !(DROP_SELF & in_target==PORT_ID) & !full.
//  - Drop event = accept & !write; drop_cnt += 1 per event, holds at all-ones.
//  - Read = out_valid & out_ready. out_valid = (occupancy != 0); out_* show entry at rd_ptr.
//  - Latency: packet written at edge N is visible on out_* after edge N (cycle N+1); no
//    same-cycle fall-through on an empty queue.
//  - Simultaneous write & read: occupancy unchanged, both pointers advance. "full" is the
//    registered occupancy==DEPTH: in drop mode a packet arriving while full is dropped even if a
//    read occurs in the same cycle.
//  - Pointers are $clog2(DEPTH) bits, wrap naturally DEPTH-1 -> 0.
//  - out_* held stable while out_valid & !out_ready. When out_valid=0, out_* are don't-care.
//  - Reset mid-operation: all queued packets lost, outputs return to reset values immediately.
// STRUCTURE
//  - packet_pkg: ADDR_WIDTH, DATA_WIDTH, packed typedef pkt_t {source,target,data}; ingress
//    stores pkt_t words.
//  - Sub-module switch_port_fifo (storage array + pointers + occupancy, push/pop/full/empty);
//    top level holds filter, drop logic, counter and handshakes.
// TESTING
//  1. Reset, DEPTH=4, DROP_ON_FULL=0: push src=1,tgt=2,data=8'hA5 with out_ready=0 ->
//     cycle+1 out_valid=1, out_data=A5, occupancy=1; raise out_ready -> next cycle out_valid=0.
//  2. Push 5 packets back-to-back, out_ready=0 -> in_ready falls after 4th; 5th held by source;
//     drain -> data order 1,2,3,4,5, drop_cnt=0.
//  3. DROP_ON_FULL=1: fill 4, push 2 more -> in_ready stays 1, drop_cnt=2, drained order 1..4.
//  4. Full queue, push and pop same cycle (drop mode) -> pushed packet dropped, drop_cnt+1,
//     occupancy=3; backpressure mode at occupancy=3 push+pop -> occupancy stays 3.
//  5. DROP_SELF=1, PORT_ID=2: push tgt=2 then tgt=3 -> only tgt=3 emerges, drop_cnt=1.
//  6. Assert rst_n=0 with 3 queued packets mid-transfer -> out_valid=0, occupancy=0, drop_cnt=0
//     asynchronously; CNT_WIDTH=2 with 5 drops -> drop_cnt saturates at 3.

Source files
------------

// File: rtl/packet_pkg.sv
// Shared packet definitions for the 4-port switch: address/payload widths,
// the packed packet word stored by every ingress FIFO, and the self-address test.
package packet_pkg;

   localparam int ADDR_WIDTH = 2;
   localparam int DATA_WIDTH = 8;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] source;
      logic [ADDR_WIDTH-1:0] target;
      logic [DATA_WIDTH-1:0] data;
   } pkt_t;

   localparam int PKT_WIDTH = $bits(pkt_t);

   // True when a packet is addressed back to the port it arrived on.
   function automatic logic is_self_addressed(
      input logic [ADDR_WIDTH-1:0] target,
      input logic [ADDR_WIDTH-1:0] port_id
   );
      return (target == port_id);
   endfunction

endpackage

// File: rtl/switch_port_fifo.sv
// Packet FIFO for one switch ingress port. Holds DEPTH pkt_t words with
// naturally wrapping pointers and an occupancy counter. The head packet is
// kept in a register that is loaded with the entry that will be at the head
// after this cycle's push/pop, so the outputs are registered and a packet
// pushed into an empty queue appears one cycle later (no fall-through).
module switch_port_fifo
   import packet_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  pkt_t                       i_din,
   output pkt_t                       o_head,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH+1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
   localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1'b1);
   localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   pkt_t             r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_count;
   pkt_t             r_head;

   logic             w_push_ok;
   logic             w_pop_ok;
   logic [PTR_W-1:0] w_rd_next;
   logic [OCC_W-1:0] w_count_left;
   logic [OCC_W-1:0] w_count_next;
   pkt_t             w_head_next;

   assign o_full   = (r_count == OCC_FULL);
   assign o_empty  = (r_count == OCC_ZERO);
   assign o_count  = r_count;
   assign o_head   = r_head;

   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;

   // Next read pointer, next occupancy and the packet that will sit at the head.
   always_comb begin
      w_rd_next    = r_rd_ptr;
      w_count_next = r_count;
      w_head_next  = '0;
      if (w_pop_ok) begin
         w_rd_next    = r_rd_ptr + PTR_ONE;
         w_count_left = r_count - OCC_ONE;
      end else begin
         w_rd_next    = r_rd_ptr;
         w_count_left = r_count;
      end
      case ({w_push_ok, w_pop_ok})
         2'b10:   w_count_next = r_count + OCC_ONE;
         2'b01:   w_count_next = r_count - OCC_ONE;
         default: w_count_next = r_count;
      endcase
      // Entries already stored win; a push only becomes head when nothing older remains.
      if (w_count_left != OCC_ZERO) begin
         w_head_next = r_mem[w_rd_next];
      end else if (w_push_ok) begin
         w_head_next = i_din;
      end else begin
         w_head_next = '0;
      end
   end

   // Storage array: written on push only, contents deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // Pointers, occupancy and the registered head packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {OCC_W{1'b0}};
         r_head   <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         r_rd_ptr <= w_rd_next;
         r_count  <= w_count_next;
         r_head   <= w_head_next;
      end
   end

endmodule

// File: rtl/switch_port_ingress.sv
// Ingress buffer for one port of the 4-port switch. Accepts packets on a
// valid/ready stream, filters self-addressed packets, optionally drops on a
// full queue instead of backpressuring, counts drops (saturating) and hands
// the queued packets to the fabric on a second valid/ready stream.
module switch_port_ingress
   import packet_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] PORT_ID      = 2'd0,
   parameter int                    DEPTH        = 4,
   parameter int                    DROP_ON_FULL = 0,
   parameter int                    DROP_SELF    = 1,
   parameter int                    CNT_WIDTH    = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_WIDTH-1:0]      in_source,
   input  logic [ADDR_WIDTH-1:0]      in_target,
   input  logic [DATA_WIDTH-1:0]      in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ADDR_WIDTH-1:0]      out_source,
   output logic [ADDR_WIDTH-1:0]      out_target,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [CNT_WIDTH-1:0]       drop_cnt
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);

   pkt_t                 w_in_pkt;
   pkt_t                 w_head;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_accept;
   logic                 w_self;
   logic                 w_write;
   logic                 w_drop;
   logic                 w_read;
   logic [CNT_WIDTH-1:0] r_drop_cnt;

   assign w_in_pkt = '{source: in_source, target: in_target, data: in_data};

   // in_ready looks only at the registered occupancy, never at out_ready.
   assign in_ready = (DROP_ON_FULL != 0) ? 1'b1 : ~w_full;

   // Accept/filter/drop decision for the packet offered this cycle.
   always_comb begin
      w_accept = in_valid & in_ready;
      w_self   = 1'b0;
      w_write  = 1'b0;
      w_drop   = 1'b0;
      if (DROP_SELF != 0) begin
         w_self = is_self_addressed(in_target, PORT_ID);
      end else begin
         w_self = 1'b0;
      end
      // "full" is the registered state, so a same-cycle read does not rescue a drop.
      w_write = w_accept & ~w_self & ~w_full;
      w_drop  = w_accept & ~w_write;
   end

   assign out_valid  = ~w_empty;
   assign w_read     = out_valid & out_ready;
   assign out_source = w_head.source;
   assign out_target = w_head.target;
   assign out_data   = w_head.data;
   assign drop_cnt   = r_drop_cnt;

   switch_port_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_write),
      .i_pop   (w_read),
      .i_din   (w_in_pkt),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (occupancy)
   );

   // Saturating count of discarded packets (full queue or self-addressed).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop_cnt <= {CNT_WIDTH{1'b0}};
      end else if (w_drop && (r_drop_cnt != CNT_MAX)) begin
         r_drop_cnt <= r_drop_cnt + CNT_ONE;
      end
   end

endmodule
